// File: rtl/aes_round_sequencer.sv
// AES round sequencer: tracks round index, round-key index and first/final flags
// for AES-128/192/256, with a done/acknowledge handshake toward the controller.
module aes_round_sequencer #(
    parameter int RW    = 4,
    parameter int NR128 = 10,
    parameter int NR192 = 12,
    parameter int NR256 = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    key_size,
    input  logic          decrypt,
    input  logic          advance,
    input  logic          abort,
    input  logic          done_ack,
    output logic [RW-1:0] round,
    output logic [RW-1:0] key_round,
    output logic [RW-1:0] nr,
    output logic          is_first,
    output logic          is_final,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t        state_r;
    logic [RW-1:0] round_r;
    logic [RW-1:0] key_round_r;
    logic [RW-1:0] nr_r;
    logic          dec_r;
    logic          is_first_r;
    logic          is_final_r;
    logic          busy_r;
    logic          done_r;
    logic          cfg_err_r;

    logic [RW-1:0] nr_sel_s;
    logic [RW-1:0] round_inc_s;

    function automatic logic [RW-1:0] nr_for_size(input logic [1:0] ks);
        logic [RW-1:0] n;
        case (ks)
            2'b00:   n = RW'(NR128);
            2'b01:   n = RW'(NR192);
            2'b10:   n = RW'(NR256);
            default: n = RW'(NR128);
        endcase
        return n;
    endfunction

    // Decryption walks the key schedule backwards; nr >= rnd always holds here.
    function automatic logic [RW-1:0] key_index(input logic dec, input logic [RW-1:0] n,
                                                input logic [RW-1:0] rnd);
        return dec ? (n - rnd) : rnd;
    endfunction

    assign nr_sel_s    = nr_for_size(key_size);
    assign round_inc_s = round_r + RW'(1);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            round_r     <= '0;
            key_round_r <= '0;
            nr_r        <= RW'(NR128);
            dec_r       <= 1'b0;
            is_first_r  <= 1'b0;
            is_final_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            if (abort) begin
                state_r     <= ST_IDLE;
                round_r     <= '0;
                key_round_r <= '0;
                is_first_r  <= 1'b0;
                is_final_r  <= 1'b0;
                busy_r      <= 1'b0;
                done_r      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if (key_size == 2'b11) begin
                                cfg_err_r <= 1'b1;
                            end else begin
                                state_r     <= ST_RUN;
                                nr_r        <= nr_sel_s;
                                dec_r       <= decrypt;
                                round_r     <= '0;
                                key_round_r <= decrypt ? nr_sel_s : '0;
                                is_first_r  <= 1'b1;
                                is_final_r  <= 1'b0;
                                busy_r      <= 1'b1;
                                done_r      <= 1'b0;
                            end
                        end else if ((state_r == ST_DONE) && done_ack) begin
                            state_r     <= ST_IDLE;
                            round_r     <= '0;
                            key_round_r <= '0;
                            done_r      <= 1'b0;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_RUN: begin
                        if (advance) begin
                            if (round_r == nr_r) begin
                                // round and key_round keep their final values for the consumer
                                state_r    <= ST_DONE;
                                is_first_r <= 1'b0;
                                is_final_r <= 1'b0;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                            end else begin
                                round_r     <= round_inc_s;
                                key_round_r <= key_index(dec_r, nr_r, round_inc_s);
                                is_first_r  <= 1'b0;
                                is_final_r  <= (round_inc_s == nr_r);
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        round_r     <= '0;
                        key_round_r <= '0;
                        is_first_r  <= 1'b0;
                        is_final_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign round     = round_r;
    assign key_round = key_round_r;
    assign nr        = nr_r;
    assign is_first  = is_first_r;
    assign is_final  = is_final_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = cfg_err_r;

endmodule

// Invariant checker for aes_round_sequencer, attached from outside the design.
module aes_round_sequencer_chk #(
    parameter int RW = 4
) (
    input logic          clk,
    input logic          rst,
    input logic [RW-1:0] round,
    input logic [RW-1:0] nr,
    input logic          is_first,
    input logic          is_final,
    input logic          busy,
    input logic          done
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_round_le_nr:    assert property (@(posedge clk) disable iff (rst) round <= nr);
    a_first_in_run:   assert property (@(posedge clk) disable iff (rst)
                                       is_first |-> (busy && (round == '0)));
    a_final_in_run:   assert property (@(posedge clk) disable iff (rst)
                                       is_final |-> (busy && (round == nr)));

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: a cycle-level reference model queues
// expected outputs; a monitor compares them against the DUT after each edge.
module tb_aes_round_sequencer;

    localparam int RW = 4;

    typedef struct packed {
        logic [RW-1:0] round;
        logic [RW-1:0] key_round;
        logic [RW-1:0] nr;
        logic          is_first;
        logic          is_final;
        logic          busy;
        logic          done;
        logic          cfg_err;
    } exp_t;

    logic          clk = 1'b1;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    key_size = 2'b00;
    logic          decrypt = 1'b0;
    logic          advance = 1'b0;
    logic          abort = 1'b0;
    logic          done_ack = 1'b0;
    logic [RW-1:0] round;
    logic [RW-1:0] key_round;
    logic [RW-1:0] nr;
    logic          is_first;
    logic          is_final;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_act;

    // Reference model: 0=idle, 1=run, 2=done
    int   m_state = 0;
    int   m_round = 0;
    int   m_nr    = 10;
    bit   m_dec   = 1'b0;
    bit   m_cfg   = 1'b0;

    aes_round_sequencer #(.RW(RW), .NR128(10), .NR192(12), .NR256(14)) dut (
        .clk(clk), .rst(rst), .start(start), .key_size(key_size), .decrypt(decrypt),
        .advance(advance), .abort(abort), .done_ack(done_ack), .round(round),
        .key_round(key_round), .nr(nr), .is_first(is_first), .is_final(is_final),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    aes_round_sequencer_chk #(.RW(RW)) u_chk (
        .clk(clk), .rst(rst), .round(round), .nr(nr), .is_first(is_first),
        .is_final(is_final), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        int   kr;
        if (m_state == 0) kr = 0;
        else if (m_dec) kr = m_nr - m_round;
        else kr = m_round;
        e.round     = RW'(m_round);
        e.key_round = RW'(kr);
        e.nr        = RW'(m_nr);
        e.is_first  = (m_state == 1) && (m_round == 0);
        e.is_final  = (m_state == 1) && (m_round == m_nr);
        e.busy      = (m_state == 1);
        e.done      = (m_state == 2);
        e.cfg_err   = m_cfg;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit ab, input bit st, input logic [1:0] ks,
                              input bit d, input bit adv, input bit ack);
        m_cfg = 1'b0;
        if (r) begin
            m_state = 0; m_round = 0; m_nr = 10; m_dec = 1'b0;
        end else if (ab) begin
            m_state = 0; m_round = 0;
        end else if (m_state != 1 && st) begin
            if (ks == 2'b11) begin
                m_cfg = 1'b1;
            end else begin
                m_nr = 10 + 2 * int'(ks);
                m_dec = d; m_round = 0; m_state = 1;
            end
        end else if (m_state == 1 && adv) begin
            if (m_round == m_nr) m_state = 2;
            else m_round = m_round + 1;
        end else if (m_state == 2 && ack) begin
            m_state = 0; m_round = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit ab, input bit st, input logic [1:0] ks,
                       input bit d, input bit adv, input bit ack);
        @(negedge clk);
        rst = r; abort = ab; start = st; key_size = ks; decrypt = d;
        advance = adv; done_ack = ack;
        model_step(r, ab, st, ks, d, adv, ack);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adv_cyc();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compare every output a moment after the active edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = '{round, key_round, nr, is_first, is_final, busy, done, cfg_err};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t got rnd=%0d kr=%0d nr=%0d first=%b final=%b busy=%b done=%b cfg=%b exp rnd=%0d kr=%0d nr=%0d first=%b final=%b busy=%b done=%b cfg=%b",
                         $time, mon_act.round, mon_act.key_round, mon_act.nr, mon_act.is_first,
                         mon_act.is_final, mon_act.busy, mon_act.done, mon_act.cfg_err,
                         mon_exp.round, mon_exp.key_round, mon_exp.nr, mon_exp.is_first,
                         mon_exp.is_final, mon_exp.busy, mon_exp.done, mon_exp.cfg_err);
            end
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle_cyc();

        // AES-128 encrypt, advance every cycle
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) adv_cyc();
        idle_cyc();

        // AES-256 decrypt from DONE, advance every third cycle
        cyc(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            adv_cyc(); idle_cyc(); idle_cyc();
        end

        // Back-to-back: start AES-192 together with done_ack
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) adv_cyc();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        // Reserved key size from IDLE, then a normal start
        cyc(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) adv_cyc();
        // Abort together with advance at round 5
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        idle_cyc(); idle_cyc();

        // Reset at round 7 of a decrypt run
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) adv_cyc();
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle_cyc();

        // Ignored inputs: start and done_ack during RUN, advance in IDLE
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) adv_cyc();
        cyc(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        adv_cyc(); adv_cyc();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 3) == 0));
        end

        idle_cyc();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Parametrised round sequencer for the AES datapath, covering AES-128, AES-192 and AES-256 (10/12/14 rounds).
- Tracks the current round and flags the initial AddRoundKey round and the final round (no MixColumns).
- Drives the round-key index in forward order for encryption and reverse order for decryption.
- Holds a done/acknowledge handshake toward the top-level controller. Sits between the control FSM, the round datapath and the key schedule.

Parameters:
- RW, 4, width of round and key_round outputs; must satisfy 2^RW > NR256.
- NR128, 10, round count for key_size=2'b00.
- NR192, 12, round count for key_size=2'b01.
- NR256, 14, round count for key_size=2'b10.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new operation; accepted only in IDLE or DONE.
- key_size  input  2  00=128, 01=192, 10=256, 11=reserved; sampled on an accepted start.
- decrypt  input  1  0=encrypt, 1=decrypt; sampled on an accepted start.
- advance  input  1  current round complete; move to the next round (RUN only).
- abort  input  1  cancel the operation and return to IDLE.
- done_ack  input  1  consumer has taken the result; clears done.
- round  output  RW  current round index, 0..nr.
- key_round  output  RW  round-key index: round if encrypting, nr-round if decrypting.
- nr  output  RW  latched round count of the current/last operation.
- is_first  output  1  high while RUN and round==0.
- is_final  output  1  high while RUN and round==nr.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- cfg_err  output  1  one-cycle pulse when start is rejected for key_size=11.

Behaviour:
- All outputs are registered and change only on the rising edge of clk.
- rst (highest priority): state=IDLE, round=0, key_round=0, nr=NR128, is_first=0, is_final=0, busy=0, done=0, cfg_err=0, latched decrypt=0.
- Priority each cycle: rst > abort > start > advance > done_ack.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start, key_size valid:
  - latch nr from key_size and latch decrypt.
  - round=0; state=RUN.
  - next cycle: busy=1, is_first=1, done=0, key_round = decrypt ? nr : 0.
- IDLE/DONE + start, key_size=11:
  - no state change; cfg_err=1 for exactly one cycle.
  - nr, round and done are unchanged.
- RUN + advance with round<nr: round=round+1; key_round updates in the same cycle as round.
- is_first deasserts once round>0. is_final asserts in the cycle round becomes nr.
- RUN + advance with round==nr:
  - state=DONE, busy=0, is_final=0, done=1.
  - round and key_round hold their last values (nr, and nr or 0).
- RUN without advance: everything holds, with no timeout.
- start while RUN: ignored.
- done_ack outside DONE: ignored. advance outside RUN: ignored.
- DONE + done_ack (no start): state=IDLE, done=0, round=0, key_round=0. nr holds.
- DONE + start: takes priority over done_ack; starts a new operation directly, so done falls the same cycle busy rises.
- abort in any state: state=IDLE, round=0, key_round=0, is_first=0, is_final=0, busy=0, done=0. nr holds. abort takes precedence over a simultaneous start or advance.
- Arithmetic:
  - round increments modulo 2^RW but never exceeds nr, guaranteed by the FSM.
  - key_round = nr - round computed in RW bits; it never underflows because round<=nr.
- Latency: accepted start to busy=1 is 1 cycle. An N-round operation needs nr+1 advance pulses from start to done (rounds 0..nr).

Test Plan:
- AES-128 encrypt: rst, start with key_size=00, decrypt=0, then advance every cycle.
  -> round steps 0..10; is_first only at round 0; is_final only at round 10; after the 11th advance, done=1, busy=0, round=10.
- AES-256 decrypt with gapped advance (every 3rd cycle):
  -> nr=14; key_round runs 14,13,..,0 while round runs 0..14; values hold between advances; done after the 15th advance.
- AES-192 with back-to-back ops: in DONE assert start (key_size=01) and done_ack together.
  -> done falls and busy rises in the same cycle; round=0, is_first=1, nr=12; is_final at round 12.
- Reserved size: start with key_size=11 from IDLE.
  -> cfg_err high exactly 1 cycle; busy=0; nr keeps its prior value.
  -> then start with key_size=00 proceeds normally.
- Abort/reset mid-run: abort at round 5 together with advance.
  -> next cycle state IDLE, round=0, flags=0, done never asserted.
  -> repeat with rst high at round 7 and confirm all outputs reach reset values on the next edge.
- Ignored inputs: start during RUN at round 3, advance in IDLE, done_ack in RUN.
  -> no change to round, nr or flags in each case.
